// File: rtl/gate_tester_pkg.sv
// Shared types and truth-table constants for the 2-input gate tester.
package gate_tester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Truth tables indexed by {in1,in2}
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

  localparam logic [2:0] ERR_MAX = 3'd4;

  function automatic logic [2:0] err_inc(input logic [2:0] cnt);
    return (cnt >= ERR_MAX) ? ERR_MAX : cnt + 3'd1;
  endfunction

endpackage

// File: rtl/gate_tester_settle_cnt.sv
// 4-bit loadable down-counter timing the APPLY hold; saturates at zero.
module gate_tester_settle_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero,
  output logic       last
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 4'd0);
  assign last = (cnt_q == 4'd1);

endmodule

// File: rtl/gate_tester.sv
// Walks a 2-input gate through all four input vectors and scores its output
// against an expected truth table.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for start; results of last run held
// ST_APPLY  | vector idx driven, waiting SETTLE cycles for y to settle
// ST_CHECK  | one cycle: compare y with TRUTH[idx], advance or finish
// ST_FINISH | one cycle: done pulse, pass latched
module gate_tester
  import gate_tester_pkg::*;
#(
  parameter logic [3:0]  TRUTH  = TT_NAND,
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       in1,
  output logic       in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] SETTLE_L = 4'(SETTLE);

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  logic       cnt_load;
  logic       cnt_dec;
  logic       cnt_zero;
  logic       cnt_last;
  logic       mism;

  gate_tester_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_L),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  assign mism = (y != TRUTH[idx_q]);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d  = ST_APPLY;
          idx_d    = 2'd0;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          err_d    = 3'd0;
          fail_d   = 4'd0;
          cnt_load = 1'b1;
        end
      end
      ST_APPLY: begin
        cnt_dec = 1'b1;
        // zero only guards against an out-of-range SETTLE of 0
        if (cnt_last || cnt_zero) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (mism) begin
          fail_d[idx_q] = 1'b1;
          err_d         = err_inc(err_q);
        end
        if (idx_q == 2'd3) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 3'd0);
        end else begin
          state_d  = ST_APPLY;
          idx_d    = idx_q + 2'd1;
          cnt_load = 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign in1      = idx_q[1];
  assign in2      = idx_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;

endmodule

// File: tb/tb_gate_tester.sv
// Directed bench: two testers (NAND/SETTLE=1 and XOR/SETTLE=3) driving modelled gates.
module tb_gate_tester;
  import gate_tester_pkg::*;

  logic clk;
  logic rst_n;
  logic start1, start3;
  logic y1, y3;
  logic in1_1, in2_1, busy_1, done_1, pass_1;
  logic in1_3, in2_3, busy_3, done_3, pass_3;
  logic [2:0] err_1, err_3;
  logic [3:0] fail_1, fail_3;

  int g1, g3;
  int checks;
  int failures;
  logic [1:0] trace [0:40];
  logic       busy_tr [0:40];

  gate_tester #(.TRUTH(TT_NAND), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
    .in1(in1_1), .in2(in2_1), .busy(busy_1), .done(done_1),
    .pass(pass_1), .err_cnt(err_1), .fail_vec(fail_1)
  );

  gate_tester #(.TRUTH(TT_XOR), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .y(y3),
    .in1(in1_3), .in2(in2_3), .busy(busy_3), .done(done_3),
    .pass(pass_3), .err_cnt(err_3), .fail_vec(fail_3)
  );

  // gate models: 0 NAND, 1 AND, 2 stuck-at-0, 3 XOR
  function automatic logic gate_fn(input int mode, input logic a, input logic b);
    case (mode)
      0:       return !(a & b);
      1:       return a & b;
      2:       return 1'b0;
      default: return a ^ b;
    endcase
  endfunction

  always_comb y1 = gate_fn(g1, in1_1, in2_1);
  always_comb y3 = gate_fn(g3, in1_3, in2_3);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_run(input bit use3, output int done_edge);
    done_edge = -1;
    @(negedge clk);
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    trace[0]   = use3 ? {in1_3, in2_3} : {in1_1, in2_1};
    busy_tr[0] = use3 ? busy_3 : busy_1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      trace[k]   = use3 ? {in1_3, in2_3} : {in1_1, in2_1};
      busy_tr[k] = use3 ? busy_3 : busy_1;
      if (use3 ? done_3 : done_1) begin
        done_edge = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in1_1, in2_1, busy_1, done_1, pass_1, err_1, fail_1} !== 13'd0) begin
      failures++;
      $display("FAIL reset_dut1 got=%b want=0", {in1_1, in2_1, busy_1, done_1, pass_1, err_1, fail_1});
    end
    checks++;
    if ({in1_3, in2_3, busy_3, done_3, pass_3, err_3, fail_3} !== 13'd0) begin
      failures++;
      $display("FAIL reset_dut3 got=%b want=0", {in1_3, in2_3, busy_3, done_3, pass_3, err_3, fail_3});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy_1, done_1, busy_3, done_3} !== 4'd0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b want=0000", {busy_1, done_1, busy_3, done_3});
    end
  endtask

  task automatic test_nand;
    int de;
    g1 = 0;
    do_run(1'b0, de);
    checks++;
    if (de !== 8) begin failures++; $display("FAIL nand_done_edge got=%0d want=8", de); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (trace[k] !== 2'(k / 2) || busy_tr[k] !== 1'b1) begin
        failures++;
        $display("FAIL nand_seq k=%0d vec=%b busy=%b want vec=%b busy=1", k, trace[k], busy_tr[k], 2'(k / 2));
      end
    end
    checks++;
    if ({pass_1, err_1, fail_1} !== {1'b1, 3'd0, 4'b0000}) begin
      failures++;
      $display("FAIL nand_result got pass=%b err=%0d fail=%b want 1/0/0000", pass_1, err_1, fail_1);
    end
    @(posedge clk); #1;
    checks++;
    if ({done_1, busy_1, in1_1, in2_1, pass_1} !== 5'b00111) begin
      failures++;
      $display("FAIL nand_after got done,busy,in1,in2,pass=%b want 00111", {done_1, busy_1, in1_1, in2_1, pass_1});
    end
  endtask

  task automatic test_stuck0;
    int de;
    g1 = 2;
    do_run(1'b0, de);
    checks++;
    if (de !== 8 || {pass_1, err_1, fail_1} !== {1'b0, 3'd3, 4'b0111}) begin
      failures++;
      $display("FAIL stuck0 got edge=%0d pass=%b err=%0d fail=%b want 8/0/3/0111", de, pass_1, err_1, fail_1);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({busy_1, pass_1, err_1, fail_1} !== {1'b0, 1'b0, 3'd3, 4'b0111}) begin
      failures++;
      $display("FAIL stuck0_hold got busy=%b pass=%b err=%0d fail=%b want 0/0/3/0111", busy_1, pass_1, err_1, fail_1);
    end
  endtask

  task automatic test_and_gate;
    int de;
    g1 = 1;
    do_run(1'b0, de);
    checks++;
    if (de !== 8 || {pass_1, err_1, fail_1} !== {1'b0, 3'd4, 4'b1111}) begin
      failures++;
      $display("FAIL and_gate got edge=%0d pass=%b err=%0d fail=%b want 8/0/4/1111", de, pass_1, err_1, fail_1);
    end
  endtask

  task automatic test_settle3;
    int de;
    g3 = 3;
    do_run(1'b1, de);
    checks++;
    if (de !== 16) begin failures++; $display("FAIL settle3_done_edge got=%0d want=16", de); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (trace[k] !== 2'(k / 4)) begin
        failures++;
        $display("FAIL settle3_seq k=%0d got=%b want=%b", k, trace[k], 2'(k / 4));
      end
    end
    checks++;
    if ({pass_3, err_3, fail_3} !== {1'b1, 3'd0, 4'b0000}) begin
      failures++;
      $display("FAIL settle3_result got pass=%b err=%0d fail=%b want 1/0/0000", pass_3, err_3, fail_3);
    end
    @(posedge clk); #1;
    checks++;
    if ({done_3, in1_3, in2_3} !== 3'b011) begin
      failures++;
      $display("FAIL settle3_after got done,in1,in2=%b want 011", {done_3, in1_3, in2_3});
    end
  endtask

  task automatic test_back_to_back;
    g1 = 1;
    @(negedge clk);
    start1 = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 8) begin
        checks++;
        if ({done_1, err_1, fail_1} !== {1'b1, 3'd4, 4'b1111}) begin
          failures++;
          $display("FAIL b2b_run1 got done=%b err=%0d fail=%b want 1/4/1111", done_1, err_1, fail_1);
        end
      end
      if (k == 9) begin
        checks++;
        if ({done_1, busy_1, err_1} !== {1'b0, 1'b0, 3'd4}) begin
          failures++;
          $display("FAIL b2b_idle got done=%b busy=%b err=%0d want 0/0/4", done_1, busy_1, err_1);
        end
      end
      if (k == 10) begin
        checks++;
        if ({busy_1, pass_1, err_1, fail_1} !== {1'b1, 1'b0, 3'd0, 4'b0000}) begin
          failures++;
          $display("FAIL b2b_restart got busy=%b pass=%b err=%0d fail=%b want 1/0/0/0000", busy_1, pass_1, err_1, fail_1);
        end
        g1 = 0;
      end
      if (k == 18) begin
        checks++;
        if ({done_1, pass_1, err_1, fail_1} !== {1'b1, 1'b1, 3'd0, 4'b0000}) begin
          failures++;
          $display("FAIL b2b_run2 got done=%b pass=%b err=%0d fail=%b want 1/1/0/0000", done_1, pass_1, err_1, fail_1);
        end
        start1 = 1'b0;
      end
      if (k == 20) begin
        checks++;
        if (busy_1 !== 1'b0) begin failures++; $display("FAIL b2b_stop got busy=%b want 0", busy_1); end
      end
    end
  endtask

  task automatic test_reset_midrun;
    int de;
    int done_seen;
    g1 = 2;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({busy_1, in1_1, in2_1, err_1} !== {1'b1, 2'b10, 3'd2}) begin
      failures++;
      $display("FAIL midrun_pre got busy=%b vec=%b err=%0d want 1/10/2", busy_1, {in1_1, in2_1}, err_1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in1_1, in2_1, busy_1, done_1, pass_1, err_1, fail_1} !== 13'd0) begin
      failures++;
      $display("FAIL midrun_reset got=%b want=0", {in1_1, in2_1, busy_1, done_1, pass_1, err_1, fail_1});
    end
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done_1) done_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (done_1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin failures++; $display("FAIL midrun_no_done got=%0d want=0", done_seen); end
    g1 = 0;
    do_run(1'b0, de);
    checks++;
    if (de !== 8 || {pass_1, err_1, fail_1} !== {1'b1, 3'd0, 4'b0000}) begin
      failures++;
      $display("FAIL midrun_rerun got edge=%0d pass=%b err=%0d fail=%b want 8/1/0/0000", de, pass_1, err_1, fail_1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    g1       = 0;
    g3       = 3;
    start1   = 1'b0;
    start3   = 1'b0;
    rst_n    = 1'b0;
    test_reset();
    test_nand();
    test_stuck0();
    test_and_gate();
    test_settle3();
    test_back_to_back();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
